// File: rtl/ttc_event_gen19.sv
// Timer/counter event generator: prescaled up/down counter with interval,
// match and overflow event pulses and a software counter restart.
// Ports:
//   pclk19, n_p_reset19    clock, async active-low reset
//   pwdata19               write data shared by all register strobes
//   cntr_ctrl_sel19        control write strobe (pwdata19[6:0])
//   interval_sel19         interval write strobe
//   match_sel19[2:0]       one-hot match 1..3 write strobes
//   count_val19            current counter value
//   cntr_ctrl_out19        control readback (bit4 reads 0)
//   interval_intr19        interval reached pulse
//   match_intr19[3:1]      match n pulses
//   overflow_intr19        free-run wrap pulse
//   restart19              software restart pulse
module ttc_event_gen19 (
  input  logic        pclk19,
  input  logic        n_p_reset19,
  input  logic [15:0] pwdata19,
  input  logic        cntr_ctrl_sel19,
  input  logic        interval_sel19,
  input  logic [2:0]  match_sel19,
  output logic [15:0] count_val19,
  output logic [6:0]  cntr_ctrl_out19,
  output logic        interval_intr19,
  output logic [3:1]  match_intr19,
  output logic        overflow_intr19,
  output logic        restart19
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned CTRL_W = 7;
  localparam int unsigned PRE_W  = 8;
  localparam int unsigned N_MAT  = 3;

  logic [CTRL_W-1:0] ctrl_q;
  logic [CNT_W-1:0]  interval_q;
  logic [CNT_W-1:0]  match_q [N_MAT];
  logic [PRE_W-1:0]  pre_q;

  logic              dis_c, intv_mode_c, dec_c, mat_en_c;
  logic              tick_c;
  logic              restart_wr_c;
  logic [CNT_W-1:0]  cnt_nxt_c;
  logic [CNT_W-1:0]  load_val_c;
  logic              int_hit_c, ovf_hit_c;
  logic [N_MAT-1:0]  mat_hit_c;

  assign dis_c        = ctrl_q[0];
  assign intv_mode_c  = ctrl_q[1];
  assign dec_c        = ctrl_q[2];
  assign mat_en_c     = ctrl_q[3];
  assign restart_wr_c = cntr_ctrl_sel19 & pwdata19[4];

  assign cntr_ctrl_out19 = ctrl_q;

  // Tick when the low prescaler bits for the selected divide ratio are all ones
  always_comb begin
    tick_c = 1'b0;
    case (ctrl_q[6:5])
      2'b00:   tick_c = 1'b1;
      2'b01:   tick_c = &pre_q[1:0];
      2'b10:   tick_c = &pre_q[3:0];
      default: tick_c = &pre_q;
    endcase
    tick_c = tick_c & ~dis_c;
  end

  // Next count and the events that update produces
  always_comb begin
    cnt_nxt_c = count_val19;
    int_hit_c = 1'b0;
    ovf_hit_c = 1'b0;
    if (!dec_c) begin
      if (intv_mode_c && (count_val19 == interval_q)) begin
        cnt_nxt_c = '0;
        int_hit_c = 1'b1;
      end else begin
        // Also covers interval mode with count above a lowered interval
        cnt_nxt_c = count_val19 + CNT_W'(1);
        ovf_hit_c = (count_val19 == {CNT_W{1'b1}});
      end
    end else if (intv_mode_c) begin
      if (count_val19 == '0) begin
        cnt_nxt_c = interval_q;
        int_hit_c = 1'b1;
      end else begin
        cnt_nxt_c = count_val19 - CNT_W'(1);
      end
    end else begin
      cnt_nxt_c = count_val19 - CNT_W'(1);
      ovf_hit_c = (count_val19 == '0);
    end
    // A tick that leaves the count unchanged never raises a match
    for (int i = 0; i < int'(N_MAT); i++) begin
      mat_hit_c[i] = mat_en_c && (cnt_nxt_c != count_val19) &&
                     (cnt_nxt_c == match_q[i]);
    end
  end

  // Restart load value follows the direction/mode bits of the same write
  always_comb begin
    load_val_c = '0;
    if (pwdata19[2]) begin
      load_val_c = pwdata19[1] ? interval_q : {CNT_W{1'b1}};
    end
  end

  // Configuration registers
  always_ff @(posedge pclk19 or negedge n_p_reset19) begin
    if (!n_p_reset19) begin
      ctrl_q     <= CTRL_W'(7'h01);
      interval_q <= '0;
      for (int i = 0; i < int'(N_MAT); i++) match_q[i] <= '0;
    end else begin
      if (cntr_ctrl_sel19) ctrl_q <= {pwdata19[6:5], 1'b0, pwdata19[3:0]};
      if (interval_sel19)  interval_q <= pwdata19;
      for (int i = 0; i < int'(N_MAT); i++) begin
        if (match_sel19[i]) match_q[i] <= pwdata19;
      end
    end
  end

  // Prescaler, counter and registered event pulses
  always_ff @(posedge pclk19 or negedge n_p_reset19) begin
    if (!n_p_reset19) begin
      pre_q           <= '0;
      count_val19     <= '0;
      interval_intr19 <= 1'b0;
      match_intr19    <= '0;
      overflow_intr19 <= 1'b0;
      restart19       <= 1'b0;
    end else if (restart_wr_c) begin
      pre_q           <= '0;
      count_val19     <= load_val_c;
      interval_intr19 <= 1'b0;
      match_intr19    <= '0;
      overflow_intr19 <= 1'b0;
      restart19       <= 1'b1;
    end else begin
      restart19       <= 1'b0;
      interval_intr19 <= 1'b0;
      match_intr19    <= '0;
      overflow_intr19 <= 1'b0;
      if (!dis_c) pre_q <= pre_q + PRE_W'(1);
      if (tick_c) begin
        count_val19     <= cnt_nxt_c;
        interval_intr19 <= int_hit_c;
        match_intr19    <= mat_hit_c;
        overflow_intr19 <= ovf_hit_c;
      end
    end
  end

endmodule

// File: doc/ttc_event_gen19.md
TTC_EVENT_GEN19 -- requirements
Module: ttc_event_gen19

Interface
REQ-001 SHALL provide: pclk19  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL provide: n_p_reset19  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide: pwdata19  input  16  write data.
REQ-004 SHALL provide: cntr_ctrl_sel19  input  1  write strobe, control register (pwdata19[6:0]).
REQ-005 SHALL provide: interval_sel19  input  1  write strobe, interval register (pwdata19[15:0]).
REQ-006 SHALL provide: match_sel19  input  3  one-hot write strobes, match registers 1..3 (pwdata19[15:0]).
REQ-007 SHALL provide: count_val19  output  16  current counter value.
REQ-008 SHALL provide: cntr_ctrl_out19  output  7  control register readback; bit4 always reads 0.
REQ-009 SHALL provide: interval_intr19  output  1  one-cycle event pulse, interval reached.
REQ-010 SHALL provide: match_intr19  output  3 ([3:1])  one-cycle event pulses, match n.
REQ-011 SHALL provide: overflow_intr19  output  1  one-cycle event pulse, free-run wrap.
REQ-012 SHALL provide: restart19  output  1  one-cycle pulse, counter restarted by software.

Function
REQ-013 Control bits SHALL be: [0] disable (1 = stopped); [1] interval mode; [2] decrement; [3] match enable; [4] counter reset (write-only, self-clearing); [6:5] prescale select.
REQ-014 Prescale select SHALL give a count tick every 1/4/16/256 pclk19 cycles for 00/01/10/11, from an 8-bit prescaler.
REQ-015 While disable=1, count_val19 and the prescaler SHALL hold, and no event pulses SHALL assert.
REQ-016 On a tick, the counter SHALL update as follows:
- increment, free-run: count+1; FFFF->0000 SHALL also pulse overflow_intr19.
- increment, interval mode: count==interval -> 0000 with interval_intr19 pulse; else count+1.
- decrement, free-run: count-1; 0000->FFFF SHALL also pulse overflow_intr19.
- decrement, interval mode: count==0000 -> interval with interval_intr19 pulse; else count-1.
REQ-017 Increment interval mode with count > interval (interval lowered while running) SHALL count up to FFFF, then wrap to 0000 with overflow_intr19.
REQ-018 Every event pulse SHALL be registered and SHALL assert in the same cycle count_val19 first shows the resulting value; it SHALL be high for exactly that one cycle per tick.
REQ-019 match_intr19[n] SHALL pulse when match enable=1 and a tick loads a count equal to match register n; multiple match bits MAY assert together.
REQ-020 No match pulse SHALL assert when the count does not change.
REQ-021 Consecutive-cycle pulses (e.g. prescale 1, interval 0, interval mode) SHALL be permitted.
REQ-022 Writing control with bit4=1 SHALL clear the prescaler and load the count with:
- 0000 for increment;
- interval for decrement interval mode;
- FFFF for decrement free-run.
It SHALL also pulse restart19 next cycle and suppress all event pulses for that cycle.
REQ-023 A counter-reset write SHALL take priority over a simultaneous tick.
REQ-024 Other control bits written in the same write SHALL take effect for the next tick.
REQ-025 An interval or match write coincident with a tick SHALL have that tick compare against the old value; the new value SHALL apply from the next tick.
REQ-026 Simultaneous strobes to different registers SHALL all be accepted.

Reset
REQ-027 While n_p_reset19=0, the block SHALL drive:
- count_val19=0000;
- control=7'b0000001, so cntr_ctrl_out19=7'h01;
- interval=0000; match 1..3=0000; prescaler=00;
- all pulse outputs=0.
REQ-028 Reset assertion mid-count SHALL abort immediately, with no pulse on release.
REQ-029 The counter SHALL stay stopped until disable is written 0.

Verification
REQ-030 Reset release, ctrl=0x02, interval=0003, prescale 00 -> count 0,1,2,3,0,...; interval_intr19 SHALL be high exactly on each 3->0 cycle.
REQ-031 ctrl=0x04 (decrement, free-run) from reset -> count FFFF with overflow_intr19 one cycle, then FFFE, FFFD.
REQ-032 match1=0005, match3=0005, ctrl=0x08 -> match_intr19 = 3'b101 for one cycle when count_val19 = 0005; no match pulse while disabled at 0005.
REQ-033 ctrl=0x20 (prescale /4) -> count advances every 4th pclk19; a write of 0x30 at count 7 -> count 0000, restart19 one cycle, no event pulse.
REQ-034 Increment interval mode, count=0010, write interval=0004 -> counts to FFFF, overflow_intr19 on wrap to 0000, then interval_intr19 at 0004->0000.
REQ-035 Assert n_p_reset19 at count 1234 mid-prescale -> all outputs to reset values asynchronously; ctrl readback = 7'h01.
